// File: rtl/register_file_scoreboard.sv
// Multi-ported register file with a hard-wired zero register, optional write bypass,
// and a per-register busy scoreboard for read-after-write hazard detection.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int BYPASS     = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    input  logic [ADDR_WIDTH-1:0] RW,
    input  logic [DATA_WIDTH-1:0] BusW,
    input  logic                  RegWr,
    input  logic                  Reserve,
    input  logic [ADDR_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB,
    output logic                  BusyA,
    output logic                  BusyB,
    output logic [ADDR_WIDTH:0]   NumBusy
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                  CW        = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]                 busy_q, busy_d;
    logic [CW-1:0]                    num_busy_q, num_busy_d;

    logic wr_en, rsv_en, inc, dec;
    logic byp_a, byp_b;

    assign wr_en  = RegWr && (RW != ZERO_ADDR);
    assign rsv_en = Reserve && (RD != ZERO_ADDR);

    // Reserve overrides a same-edge clear, so the counter only drops when the
    // written register is not re-reserved on that edge.
    assign inc = rsv_en && !busy_q[RD];
    assign dec = wr_en && busy_q[RW] && !(rsv_en && (RD == RW));

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        num_busy_d = num_busy_q + CW'(inc) - CW'(dec);
        if (wr_en) begin
            regs_d[RW] = BusW;
            busy_d[RW] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[RD] = 1'b1;
        end
    end

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            regs_q     <= '0;
            busy_q     <= '0;
            num_busy_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            num_busy_q <= num_busy_d;
        end
    end

    assign byp_a = (BYPASS != 0) && wr_en && (RW == RA);
    assign byp_b = (BYPASS != 0) && wr_en && (RW == RB);

    always_comb begin
        BusA = '0;
        BusB = '0;
        if (RA != ZERO_ADDR) BusA = byp_a ? BusW : regs_q[RA];
        if (RB != ZERO_ADDR) BusB = byp_b ? BusW : regs_q[RB];
    end

    // A register whose producer is writing back this cycle is no longer a hazard.
    assign BusyA   = (RA != ZERO_ADDR) && busy_q[RA] && !byp_a;
    assign BusyB   = (RB != ZERO_ADDR) && busy_q[RB] && !byp_b;
    assign NumBusy = num_busy_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_register_file_scoreboard;

    logic        Clk, Reset, RegWr, Reserve;
    logic [4:0]  RA, RB, RW, RD;
    logic [63:0] BusW;
    logic [63:0] BusA, BusB, BusA_nb, BusB_nb;
    logic        BusyA, BusyB, BusyA_nb, BusyB_nb;
    logic [5:0]  NumBusy, NumBusy_nb;

    register_file_scoreboard #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .Reserve(Reserve), .RD(RD), .BusA(BusA), .BusB(BusB), .BusyA(BusyA), .BusyB(BusyB),
        .NumBusy(NumBusy));

    register_file_scoreboard #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .Reserve(Reserve), .RD(RD), .BusA(BusA_nb), .BusB(BusB_nb), .BusyA(BusyA_nb),
        .BusyB(BusyB_nb), .NumBusy(NumBusy_nb));

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    // Monitor: whenever the outputs are presented for sampling, drain the queue.
    initial begin
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                exp_t        e;
                logic [63:0] act;
                e = q.pop_front();
                case (e.kind)
                    0:       act = BusA;
                    1:       act = BusB;
                    2:       act = 64'(BusyA);
                    3:       act = 64'(BusyB);
                    4:       act = 64'(NumBusy);
                    5:       act = BusA_nb;
                    6:       act = 64'(NumBusy_nb);
                    7:       act = BusB_nb;
                    8:       act = 64'(BusyA_nb);
                    default: act = 64'(BusyB_nb);
                endcase
                n_tests++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input int k, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> chk_ev;
        #1;
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                         input logic [63:0] busw, input logic regwr, input logic rsv,
                         input logic [4:0] rd);
        @(posedge Clk);
        #1;
        RA = ra; RB = rb; RW = rw; BusW = busw; RegWr = regwr; Reserve = rsv; RD = rd;
    endtask

    task automatic fall();
        @(negedge Clk);
        #1;
        RegWr   = 1'b0;
        Reserve = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; RegWr = 1'b0; Reserve = 1'b0;
        RA = '0; RB = '0; RW = '0; RD = '0; BusW = '0;
        #1 Reset = 1'b1;
        #1;
        chk("rst_busa", 0, 64'd0);
        chk("rst_busya", 2, 64'd0);
        chk("rst_numbusy", 4, 64'd0);
        sample();
        @(posedge Clk);
        #1 Reset = 1'b0;

        // Fill registers 0..30 with their index.
        for (int i = 0; i < 31; i++) begin
            drive(5'd0, 5'd0, 5'(i), 64'(i), 1'b1, 1'b0, 5'd0);
            fall();
        end
        foreach (q[i]) ; // queue is empty here
        for (int i = 0; i < 31; i += 6) begin
            RA = 5'(i);
            RB = 5'(i + 1);
            chk("fill_busa", 0, 64'(i));
            chk("fill_busb", 1, (i == 30) ? 64'd0 : 64'(i + 1));
            chk("fill_busb_nb", 7, (i == 30) ? 64'd0 : 64'(i + 1));
            sample();
        end
        chk("fill_numbusy", 4, 64'd0);
        sample();

        // Zero register: writes and reserves have no effect.
        drive(5'd31, 5'd31, 5'd31, 64'h12345678, 1'b1, 1'b1, 5'd31);
        chk("zero_pre_busa", 0, 64'd0);
        chk("zero_pre_busb", 1, 64'd0);
        chk("zero_pre_busya", 2, 64'd0);
        sample();
        fall();
        chk("zero_post_busa", 0, 64'd0);
        chk("zero_post_busb", 1, 64'd0);
        chk("zero_post_busya", 2, 64'd0);
        chk("zero_post_numbusy", 4, 64'd0);
        sample();

        // Bypass versus no bypass.
        drive(5'd13, 5'd0, 5'd13, 64'hABCD, 1'b1, 1'b0, 5'd0);
        chk("byp_pre_busa", 0, 64'hABCD);
        chk("byp_pre_busya", 2, 64'd0);
        chk("nobyp_pre_busa", 5, 64'd13);
        sample();
        fall();
        chk("byp_post_busa", 0, 64'hABCD);
        chk("nobyp_post_busa", 5, 64'hABCD);
        sample();

        // Reserve two registers, then retire one.
        drive(5'd10, 5'd11, 5'd0, 64'd0, 1'b0, 1'b1, 5'd10);
        fall();
        drive(5'd10, 5'd11, 5'd0, 64'd0, 1'b0, 1'b1, 5'd11);
        fall();
        chk("rsv_numbusy", 4, 64'd2);
        chk("rsv_busya", 2, 64'd1);
        chk("rsv_busyb", 3, 64'd1);
        chk("rsv_numbusy_nb", 6, 64'd2);
        chk("rsv_busya_nb", 8, 64'd1);
        chk("rsv_busyb_nb", 9, 64'd1);
        sample();
        drive(5'd10, 5'd11, 5'd10, 64'h1010, 1'b1, 1'b0, 5'd0);
        chk("wb_pre_busya", 2, 64'd0);
        chk("wb_pre_busa", 0, 64'h1010);
        chk("wb_pre_busya_nb", 8, 64'd1);
        sample();
        fall();
        chk("wb_post_busya", 2, 64'd0);
        chk("wb_post_busa", 0, 64'h1010);
        chk("wb_post_numbusy", 4, 64'd1);
        sample();

        // Same-edge reserve and write to one register: reserve wins, data lands.
        drive(5'd11, 5'd0, 5'd11, 64'h103000, 1'b1, 1'b1, 5'd11);
        fall();
        chk("coll_busya", 2, 64'd1);
        chk("coll_busa", 0, 64'h103000);
        chk("coll_numbusy", 4, 64'd1);
        sample();
        drive(5'd11, 5'd0, 5'd0, 64'd0, 1'b0, 1'b1, 5'd11);
        fall();
        chk("rerev_numbusy", 4, 64'd1);
        sample();

        // Write clears 11 while 12 is reserved: net zero.
        drive(5'd11, 5'd12, 5'd11, 64'h11, 1'b1, 1'b1, 5'd12);
        fall();
        chk("swap_numbusy", 4, 64'd1);
        chk("swap_busya", 2, 64'd0);
        chk("swap_busyb", 3, 64'd1);
        sample();
        drive(5'd13, 5'd12, 5'd0, 64'd0, 1'b0, 1'b1, 5'd20);
        fall();
        drive(5'd13, 5'd12, 5'd0, 64'd0, 1'b0, 1'b1, 5'd21);
        fall();
        chk("pre_rst_numbusy", 4, 64'd3);
        chk("pre_rst_busa", 0, 64'hABCD);
        chk("pre_rst_busyb", 3, 64'd1);
        sample();

        // Asynchronous reset while Clk is high.
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("arst_busa", 0, 64'd0);
        chk("arst_busb", 1, 64'd0);
        chk("arst_busyb", 3, 64'd0);
        chk("arst_numbusy", 4, 64'd0);
        sample();

        // Falling edge under reset must not write.
        drive(5'd5, 5'd13, 5'd5, 64'h55, 1'b1, 1'b1, 5'd5);
        fall();
        chk("rsthold_busa", 0, 64'd0);
        chk("rsthold_busa_nb", 5, 64'd0);
        chk("rsthold_numbusy", 4, 64'd0);
        sample();
        Reset = 1'b0;
        chk("rstrel_busa", 0, 64'd0);
        chk("rstrel_busb", 1, 64'd0);
        sample();
        drive(5'd5, 5'd13, 5'd5, 64'h77, 1'b1, 1'b0, 5'd0);
        fall();
        chk("after_rst_busa", 0, 64'h77);
        chk("after_rst_busa_nb", 5, 64'h77);
        sample();

        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
